// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int OCC_W = 2;

  // Payload carried from execute to memory; width sets DATA_WIDTH for that stage.
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
  } ex_mem_payload_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for per-stage performance counters
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Holds at all-ones rather than wrapping so long stalls stay visible.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - valid/ready pipeline stage register with 2-entry skid buffer
// in_ready decodes state only, so the ready path between stages is registered.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]      occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  skid_state_t           state_q;
  skid_state_t           state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A same-cycle in_fire is swallowed here: upstream saw it accepted.
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    case (state_q)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid & ~out_ready),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - directed self-checking bench for pipe_skid_stage
module tb_pipe_skid_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_cycles;

  int checks;
  int failures;

  pipe_skid_stage #(
    .DATA_WIDTH(32), .CLEAR_ON_FLUSH(1'b1), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  pipe_skid_stage #(
    .DATA_WIDTH(8), .CLEAR_ON_FLUSH(1'b0), .CNT_WIDTH(3)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cycles(s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b0;

    // reset held two cycles with a valid beat offered
    step();
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_stall", stall_cycles, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check_eq("rst_idle_valid", out_valid, 0);

    // full-throughput streaming
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      step();
      check_eq($sformatf("stream_data_%0d", i), out_data, i);
      check_eq($sformatf("stream_occ_%0d", i), occupancy, 1);
      check_eq($sformatf("stream_rdy_%0d", i), in_ready, 1);
      check_eq($sformatf("stream_vld_%0d", i), out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check_eq("stream_drain_occ", occupancy, 0);
    check_eq("stream_stall", stall_cycles, 0);

    // back-pressure: A then B, C offered but refused
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    check_eq("bp_a_occ", occupancy, 1);
    in_data = 32'hB;
    step();
    check_eq("bp_full_occ", occupancy, 2);
    check_eq("bp_full_rdy", in_ready, 0);
    check_eq("bp_full_data", out_data, 32'hA);
    in_data = 32'hC;
    step();
    check_eq("bp_c_refused_occ", occupancy, 2);
    check_eq("bp_c_refused_data", out_data, 32'hA);
    check_eq("bp_stall", stall_cycles, 2);
    out_ready = 1'b1;
    step();
    check_eq("bp_out_b", out_data, 32'hB);
    check_eq("bp_out_b_occ", occupancy, 1);
    step();
    check_eq("bp_out_c", out_data, 32'hC);
    check_eq("bp_out_c_occ", occupancy, 1);
    in_valid = 1'b0;
    step();
    check_eq("bp_drained_valid", out_valid, 0);
    check_eq("bp_stall_final", stall_cycles, 2);

    // flush while FULL with an incoming beat
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    check_eq("fl_pre_occ", occupancy, 2);
    check_eq("fl_pre_stall", stall_cycles, 3);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hC;
    step();
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_occ", occupancy, 0);
    check_eq("fl_data", out_data, 0);
    check_eq("fl_rdy", in_ready, 1);
    check_eq("fl_stall", stall_cycles, 3);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check_eq("fl_no_c_valid", out_valid, 0);
    check_eq("fl_no_c_data", out_data, 0);

    // reset beats flush while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD;
    step();
    in_data = 32'hE;
    step();
    check_eq("rp_pre_occ", occupancy, 2);
    check_eq("rp_pre_stall", stall_cycles, 4);
    rst_n = 1'b0; flush = 1'b1;
    step();
    check_eq("rp_valid", out_valid, 0);
    check_eq("rp_rdy", in_ready, 1);
    check_eq("rp_data", out_data, 0);
    check_eq("rp_occ", occupancy, 0);
    check_eq("rp_stall", stall_cycles, 0);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step();

    // 3-bit counter saturation, then flush with data retained
    s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
    step();
    s_in_valid = 1'b0;
    check_eq("sat_start", s_stall_cycles, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("sat_cnt_%0d", k), s_stall_cycles, (k > 7) ? 7 : k);
    end
    check_eq("sat_data_held", s_out_data, 8'h5A);
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    check_eq("sat_fl_valid", s_out_valid, 0);
    check_eq("sat_fl_occ", s_occupancy, 0);
    check_eq("sat_fl_data_kept", s_out_data, 8'h5A);
    check_eq("sat_fl_stall", s_stall_cycles, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
